// File: rtl/tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// tx_sched_pkg : shared state encoding and default sizes for tx_scheduler
// Rev 1.0
// ============================================================================
package tx_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int NB_DATA_DEF = 8;
  localparam int N_REQ_DEF   = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND,
    S_GAP  = ST_GAP
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational requester picker; round robin from ptr_i when
// TX_SCHED_ROUND_ROBIN_EN is defined, otherwise lowest index wins.
// Rev 1.0
// ============================================================================
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int NB_ID = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [NB_ID-1:0] ptr_i,
  output logic             found_o,
  output logic [NB_ID-1:0] winner_o
);

`ifdef TX_SCHED_ROUND_ROBIN_EN
  localparam int NB_IX = NB_ID + 1;

  logic [NB_IX-1:0] idx;

  // One extra bit lets ptr+i be folded back below N_REQ for non power-of-two sizes.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_i} + NB_IX'(i);
      if (idx >= NB_IX'(N_REQ)) begin
        idx = idx - NB_IX'(N_REQ);
      end
      if (!found_o && req_i[idx[NB_ID-1:0]]) begin
        found_o  = 1'b1;
        winner_o = idx[NB_ID-1:0];
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_o && req_i[i]) begin
        found_o  = 1'b1;
        winner_o = NB_ID'(i);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
// tx_scheduler : grants one byte requester at a time onto the UART tx and
// acks it after the stop bit. Macro TX_SCHED_ROUND_ROBIN_EN selects round robin.
// Rev 1.0
// ============================================================================
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter  int NB_DATA = NB_DATA_DEF,
  parameter  int N_REQ   = N_REQ_DEF,
  localparam int NB_ID   = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_tx_valid,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic [NB_ID-1:0]         o_grant_id
);

  state_e             state_q;
  logic [NB_DATA-1:0] data_q;
  logic [NB_ID-1:0]   grant_q;
  logic [N_REQ-1:0]   ack_q;
  logic               valid_q;
  logic               busy_q;

  logic               arb_found;
  logic [NB_ID-1:0]   arb_winner;
  logic [NB_ID-1:0]   ptr;
  logic [NB_DATA-1:0] sel_data;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i    (i_req),
    .ptr_i    (ptr),
    .found_o  (arb_found),
    .winner_o (arb_winner)
  );

  assign sel_data = i_data[arb_winner*NB_DATA +: NB_DATA];

`ifdef TX_SCHED_ROUND_ROBIN_EN
  logic [NB_ID-1:0] ptr_q;
  logic [NB_ID-1:0] ptr_d;

  assign ptr_d = (arb_winner == NB_ID'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q <= '0;
    end else if (state_q == S_IDLE && arb_found) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // All outputs are registered; the GAP cycle drops valid before tx goes idle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            state_q <= S_SEND;
            data_q  <= sel_data;
            grant_q <= arb_winner;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SEND: begin
          if (i_tx_done) begin
            state_q        <= S_GAP;
            valid_q        <= 1'b0;
            ack_q[grant_q] <= 1'b1;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack      = ack_q;
  assign o_tx_valid = valid_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;
  assign o_grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tx_scheduler : directed self-checking bench for tx_scheduler (N_REQ=4)
// Rev 1.0
// ============================================================================
module tb_tx_scheduler;

  localparam int NB_DATA = 8;
  localparam int N_REQ   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic        done_man = 1'b0;
  logic        done_mdl = 1'b0;
  logic        done;
  logic [3:0]  ack;
  logic        valid;
  logic [7:0]  txd;
  logic        busy;
  logic [1:0]  gid;

  int vectors = 0;
  int miscompares = 0;

  logic       model_en = 1'b0;
  int         mcnt = 0;
  int         n_sent = 0;
  logic [7:0] sent [4];

  assign done = done_man | done_mdl;

  tx_scheduler #(
    .NB_DATA (NB_DATA),
    .N_REQ   (N_REQ)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_req      (req),
    .i_data     (data),
    .o_ack      (ack),
    .o_tx_valid (valid),
    .o_tx_data  (txd),
    .i_tx_done  (done),
    .o_busy     (busy),
    .o_grant_id (gid)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: accepts a byte while idle, pulses done in its last clock.
  always @(posedge clk) begin
    done_mdl <= 1'b0;
    if (model_en) begin
      if (mcnt == 0) begin
        if (valid && !done_mdl) begin
          if (n_sent < 4) sent[n_sent] <= txd;
          n_sent <= n_sent + 1;
          mcnt   <= 6;
        end
      end else begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) done_mdl <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] eb, input int eid, input int wait_cyc, input bit drop);
    logic [3:0] eack;
    eack = 4'b0001 << eid;
    tick();
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL grant_valid: got %0b expected 1", valid); end
    vectors++; if (txd !== eb) begin miscompares++; $display("FAIL grant_data: got %02h expected %02h", txd, eb); end
    vectors++; if (gid !== 2'(eid)) begin miscompares++; $display("FAIL grant_id: got %0d expected %0d", gid, eid); end
    vectors++; if (busy !== 1'b1 || ack !== 4'b0) begin miscompares++; $display("FAIL send_busy_ack: got busy=%0b ack=%04b expected busy=1 ack=0000", busy, ack); end
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      vectors++; if (valid !== 1'b1 || txd !== eb) begin miscompares++; $display("FAIL hold_send: got valid=%0b data=%02h expected 1 %02h", valid, txd, eb); end
    end
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL gap_valid: got %0b expected 0", valid); end
    vectors++; if (ack !== eack) begin miscompares++; $display("FAIL gap_ack: got %04b expected %04b", ack, eack); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy: got %0b expected 1", busy); end
    if (drop) req[eid] = 1'b0;
    tick();
    vectors++; if (ack !== 4'b0 || busy !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL idle_after: got ack=%04b busy=%0b valid=%0b expected 0000 0 0", ack, busy, valid); end
    vectors++; if (txd !== eb || gid !== 2'(eid)) begin miscompares++; $display("FAIL hold_regs: got data=%02h id=%0d expected %02h %0d", txd, gid, eb, eid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_valid_busy: got %0b %0b expected 0 0", valid, busy); end
    vectors++; if (txd !== 8'h00 || gid !== 2'd0 || ack !== 4'b0) begin miscompares++; $display("FAIL reset_regs: got data=%02h id=%0d ack=%04b expected 0", txd, gid, ack); end
    rst_n = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_contention();
    data = 32'h13121110;
    req  = 4'b1111;
`ifdef TX_SCHED_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) send_one(8'h10 + 8'(i), i, 2, 1'b1);
`else
    for (int i = 0; i < 3; i++) send_one(8'h10, 0, 2, 1'b0);
    req = 4'b0000;
`endif
  endtask

  task automatic test_single();
    data = 32'h00A50000;
    req  = 4'b0100;
    send_one(8'hA5, 2, 7, 1'b1);
  endtask

  task automatic test_wrap();
    data = 32'h77000000;
    req  = 4'b1000;
    send_one(8'h77, 3, 1, 1'b1);
    data = 32'h00320030;
    req  = 4'b0101;
    send_one(8'h30, 0, 1, 1'b1);
    send_one(8'h32, 2, 1, 1'b1);
  endtask

  task automatic test_ignored();
    data = 32'h00003C00;
    req  = 4'b0010;
    tick();
    vectors++; if (valid !== 1'b1 || txd !== 8'h3C || gid !== 2'd1) begin miscompares++; $display("FAIL ign_grant: got valid=%0b data=%02h id=%0d expected 1 3c 1", valid, txd, gid); end
    data = 32'h0000FF00;
    req  = 4'b0000;
    repeat (3) tick();
    vectors++; if (valid !== 1'b1 || txd !== 8'h3C) begin miscompares++; $display("FAIL ign_hold: got valid=%0b data=%02h expected 1 3c", valid, txd); end
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    vectors++; if (ack !== 4'b0010 || valid !== 1'b0) begin miscompares++; $display("FAIL ign_ack: got ack=%04b valid=%0b expected 0010 0", ack, valid); end
    tick();
    vectors++; if (busy !== 1'b0 || txd !== 8'h3C) begin miscompares++; $display("FAIL ign_idle: got busy=%0b data=%02h expected 0 3c", busy, txd); end
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    vectors++; if (busy !== 1'b0 || valid !== 1'b0 || ack !== 4'b0) begin miscompares++; $display("FAIL spurious_done: got busy=%0b valid=%0b ack=%04b expected 0 0 0000", busy, valid, ack); end
    tick();
    vectors++; if (busy !== 1'b0 || ack !== 4'b0) begin miscompares++; $display("FAIL spurious_after: got busy=%0b ack=%04b expected 0 0000", busy, ack); end
  endtask

  task automatic test_reset_mid();
    data = 32'h00005B5A;
    req  = 4'b0001;
    tick();
    vectors++; if (valid !== 1'b1 || gid !== 2'd0) begin miscompares++; $display("FAIL pre_reset_grant: got valid=%0b id=%0d expected 1 0", valid, gid); end
    req = 4'b0011;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (valid !== 1'b0 || busy !== 1'b0 || ack !== 4'b0) begin miscompares++; $display("FAIL async_reset_ctl: got valid=%0b busy=%0b ack=%04b expected 0", valid, busy, ack); end
    vectors++; if (txd !== 8'h00 || gid !== 2'd0) begin miscompares++; $display("FAIL async_reset_regs: got data=%02h id=%0d expected 00 0", txd, gid); end
    tick();
    vectors++; if (busy !== 1'b0 || ack !== 4'b0) begin miscompares++; $display("FAIL held_reset: got busy=%0b ack=%04b expected 0 0000", busy, ack); end
    #3 rst_n = 1'b1;
    send_one(8'h5A, 0, 1, 1'b1);
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e0;
    logic [7:0] e1;
    int cyc;
`ifdef TX_SCHED_ROUND_ROBIN_EN
    e0 = 8'hC3; e1 = 8'h55;
`else
    e0 = 8'h55; e1 = 8'hC3;
`endif
    model_en = 1'b1;
    data = 32'hC3000055;
    req  = 4'b1001;
    cyc  = 0;
    while (req != 4'b0 && cyc < 300) begin
      tick();
      req = req & ~ack;
      cyc++;
    end
    vectors++; if (req !== 4'b0) begin miscompares++; $display("FAIL e2e_timeout: got req=%04b expected 0000", req); end
    repeat (30) tick();
    vectors++; if (n_sent !== 2) begin miscompares++; $display("FAIL e2e_count: got %0d frames expected 2", n_sent); end
    vectors++; if (sent[0] !== e0) begin miscompares++; $display("FAIL e2e_first: got %02h expected %02h", sent[0], e0); end
    vectors++; if (sent[1] !== e1) begin miscompares++; $display("FAIL e2e_second: got %02h expected %02h", sent[1], e1); end
    vectors++; if (busy !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL e2e_idle: got busy=%0b valid=%0b expected 0 0", busy, valid); end
    model_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_scheduler.md
# tx_scheduler

Arbitrates N_REQ byte-producing requesters onto the single UART transmitter. The transmitter is free-running on baud_rate_generator ticks. The scheduler grants one requester at a time, latches its byte, and drives the transmitter's valid/data inputs. It holds the grant until the transmitter reports the end of the stop bit, then acknowledges the requester. It sits between the application side (ALU result path, status/echo sources) and tx.

## Interface
- NB_DATA, 8, bits per UART data byte
- N_REQ, 4, number of requesters; valid range 2..16
- NB_ID, $clog2(N_REQ), width of the grant index (derived, not overridden)

Ports:
- i_clk  in  1  system clock, same clock as tx and baud_rate_generator
- i_reset  in  1  asynchronous, active-low reset
- i_req  in  N_REQ  level request, one bit per requester
- i_data  in  N_REQ*NB_DATA  requester bytes; requester k occupies bits [k*NB_DATA +: NB_DATA]
- o_ack  out  N_REQ  one-cycle pulse to the served requester when its byte has been fully sent
- o_tx_valid  out  1  to tx i_valid
- o_tx_data  out  NB_DATA  to tx i_data; stable while o_tx_valid is high
- i_tx_done  in  1  one-cycle pulse from tx, in the last clock of the stop bit
- o_busy  out  1  high in any state other than IDLE
- o_grant_id  out  NB_ID  index of the current/last granted requester

## Operation
- States: IDLE, SEND, GAP.
- **IDLE**
  - If any i_req bit is high: pick a winner, latch its byte into o_tx_data, latch its index into o_grant_id, go to SEND.
  - Otherwise stay in IDLE.
- **SEND**
  - o_tx_valid is high.
  - Stay until i_tx_done is sampled high, then go to GAP.
  - i_req changes during SEND are ignored. Dropping the winner's request does not abort the byte.
  - Changes on i_data after the grant are ignored.
- **GAP**
  - Exactly one cycle.
  - o_ack[o_grant_id] is high and o_tx_valid is low.
  - Next state is IDLE.
- Requester contract: hold i_req high until o_ack. Deassert it on the edge ending the ack cycle unless another byte is wanted.
- o_ack is one-hot or all zero.
- o_tx_data and o_grant_id hold their last value outside SEND.
- i_tx_done outside SEND is ignored.
- Reset, at any time including mid-byte:
  - state goes to IDLE
  - o_tx_valid=0, o_tx_data=0, o_ack=0, o_busy=0, o_grant_id=0
  - round-robin pointer goes to 0
  - the byte in flight is dropped and not acknowledged

## Timing
- Grant latency: i_req sampled at edge k in IDLE → o_tx_valid high from edge k through the edge that samples i_tx_done.
- i_tx_done sampled at edge d:
  - o_tx_valid low and o_ack high during the cycle d..d+1
  - IDLE at d+1
  - earliest next grant at edge d+2
- o_tx_valid is therefore low on the first cycle in which tx is idle again, so tx never retransmits the same byte.
- Minimum spacing is 2 clocks between i_tx_done and the next o_tx_valid rise.
- Requests arriving during SEND or GAP are considered at the next IDLE evaluation. None is lost while it is held.
- o_busy is registered and equals (state != IDLE).

## Configuration
- Macro `TX_SCHED_ROUND_ROBIN_EN`.
- Defined:
  - round-robin arbitration; search starts at pointer p and wraps modulo N_REQ
  - first requester found wins
  - on each grant, p becomes winner+1, with N_REQ-1 wrapping to 0
- Undefined:
  - fixed priority; lowest index wins
  - pointer register is not built, and p is treated as 0
- All other behaviour is identical.

## Structure
- Package tx_sched_pkg holds:
  - state encoding localparams ST_IDLE, ST_SEND, ST_GAP, in 2 bits
  - default NB_DATA and N_REQ constants
- Sub-module rr_arbiter:
  - combinational picker taking i_req and the pointer
  - returns a found flag and the winner index
  - contains the fixed-priority fallback under the macro
- Top-level tx_scheduler holds the FSM, data/grant registers, pointer and ack generation.

## Test plan
- Single request: i_req=4'b0100 with byte 0xA5 at slot 2, tx done pulsed 8 cycles later:
  - o_tx_valid high 1 cycle after the request, o_tx_data=0xA5, o_grant_id=2
  - o_ack=4'b0100 for exactly one cycle, o_busy back to 0 after GAP
- Contention: all four requesters hold i_req with bytes 0x10..0x13, each held until acked:
  - with round robin, bytes go out in order 0x10, 0x11, 0x12, 0x13
  - without the macro, 0x10 is sent repeatedly while requester 0 re-requests
- Wrap-around: last grant was id 3; requesters 0 and 2 then request → id 0 is served first (round robin).
- Ignored inputs:
  - i_data of the winner changed and i_req dropped during SEND → the originally latched byte is still sent and acked
  - spurious i_tx_done in IDLE → no state change
- Reset mid-byte: assert i_reset low during SEND:
  - all outputs 0 immediately (asynchronously), no o_ack
  - after release, a pending request is granted with pointer 0
- End-to-end: baud_rate_generator + tx + scheduler, two requesters sending 0x55 and 0xC3:
  - serial line shows both frames back to back, start/stop bits correct
  - no duplicate frame
